// File: rtl/fir_out_requant.sv
// FIR output stage: rounds, scales and saturates the wide accumulator result to a
// narrow sample, then buffers it in a first-word-fall-through FIFO with sticky status.
module fir_out_requant #(
  parameter int IN_W       = 33,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IN_W-1:0]                 data_in,
  input  logic                            valid_in,
  output logic [OUT_W-1:0]                data_out,
  output logic                            valid_out,
  input  logic                            ready_out,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            sat_flag,
  output logic                            ovf_flag,
  input  logic                            clr_flags
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int R_W   = IN_W + 1;

  localparam logic signed [R_W-1:0] RND   = R_W'(64'd1 << (SHIFT - 1));
  localparam logic signed [R_W-1:0] Q_MAX = R_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [R_W-1:0] Q_MIN = R_W'(-(2 ** (OUT_W - 1)));

  // Stage 1: round half up, arithmetic shift, clip to the output range
  logic signed [R_W-1:0] r_ext;
  logic signed [R_W-1:0] q;
  logic                  clip;
  logic [OUT_W-1:0]      sat_val;

  always_comb begin
    r_ext   = $signed({data_in[IN_W-1], data_in}) + RND;
    q       = r_ext >>> SHIFT;
    clip    = 1'b0;
    sat_val = q[OUT_W-1:0];
    if (q > Q_MAX) begin
      clip    = 1'b1;
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (q < Q_MIN) begin
      clip    = 1'b1;
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  logic             s1_valid;
  logic [OUT_W-1:0] s1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) s1_data <= sat_val;
    end
  end

  // Handshake: a sample transfers on any edge where valid_out=1 and ready_out=1;
  // data_out holds the head entry and stays stable while valid_out=1 and ready_out=0.
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  always_comb begin
    valid_out = (level != '0);
    full      = (level == LVL_W'(FIFO_DEPTH));
    pop       = valid_out & ready_out;
    push_ok   = s1_valid & (~full | pop);
    drop      = s1_valid & full & ~pop;
    data_out  = valid_out ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= s1_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Set events take priority over a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (valid_in && clip) sat_flag <= 1'b1;
      else if (clr_flags)   sat_flag <= 1'b0;
      if (drop)             ovf_flag <= 1'b1;
      else if (clr_flags)   ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: rounding, saturation, backpressure,
// overflow, full-rate flow through a full FIFO and mid-stream reset.
module tb_fir_out_requant;

  logic        clk;
  logic        rst;
  logic [32:0] data_in;
  logic        valid_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic        ready_out;
  logic [3:0]  level;
  logic        sat_flag;
  logic        ovf_flag;
  logic        clr_flags;

  int n_checks = 0;
  int n_err    = 0;

  fir_out_requant dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .level     (level),
    .sat_flag  (sat_flag),
    .ovf_flag  (ovf_flag),
    .clr_flags (clr_flags)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: drive on falling edges, outputs sampled on falling edges
  task automatic send1(input logic [32:0] d);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = d;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic stream(input int first, input int count);
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = 33'(first + k) << 15;
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  logic [32:0] rnd_in  [4];
  logic [15:0] rnd_exp [4];

  initial begin
    rnd_in[0] = 33'(16384);   rnd_exp[0] = 16'h0001;
    rnd_in[1] = 33'(16383);   rnd_exp[1] = 16'h0000;
    rnd_in[2] = 33'(-16384);  rnd_exp[2] = 16'h0000;
    rnd_in[3] = 33'(-16385);  rnd_exp[3] = 16'hFFFF;

    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b1; clr_flags = 1'b0;
    #12;
    check("rst_valid", 16'(valid_out), 16'h0);
    check("rst_level", 16'(level), 16'h0);
    check("rst_data", data_out, 16'h0);
    check("rst_sat", 16'(sat_flag), 16'h0);
    check("rst_ovf", 16'(ovf_flag), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // rounding and two-cycle latency
    for (int i = 0; i < 4; i++) begin
      send1(rnd_in[i]);
      check("t1_early", 16'(valid_out), 16'h0);
      @(negedge clk);
      check("t1_valid", 16'(valid_out), 16'h1);
      check("t1_data", data_out, rnd_exp[i]);
      @(negedge clk);
      check("t1_empty", 16'(level), 16'h0);
    end

    // saturation and flag clearing
    send1(33'h0_8000_0000);
    check("t2_sat_set", 16'(sat_flag), 16'h1);
    @(negedge clk);
    check("t2_pos_clip", data_out, 16'h7FFF);
    send1(33'h1_0000_0000);
    @(negedge clk);
    check("t2_neg_clip", data_out, 16'h8000);
    pulse_clr();
    check("t2_sat_clr", 16'(sat_flag), 16'h0);
    @(negedge clk);
    clr_flags = 1'b1;
    valid_in  = 1'b1;
    data_in   = 33'h0_8000_0000;
    @(negedge clk);
    clr_flags = 1'b0;
    valid_in  = 1'b0;
    check("t2_set_wins", 16'(sat_flag), 16'h1);
    @(negedge clk);
    check("t2_clip_again", data_out, 16'h7FFF);
    pulse_clr();
    check("t2_sat_clr2", 16'(sat_flag), 16'h0);

    // backpressure
    ready_out = 1'b0;
    stream(1, 8);
    @(negedge clk);
    check("t3_level", 16'(level), 16'd8);
    check("t3_head", data_out, 16'd1);
    check("t3_ovf", 16'(ovf_flag), 16'h0);
    ready_out = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t3_valid", 16'(valid_out), 16'h1);
      check("t3_order", data_out, 16'(i));
      @(negedge clk);
    end
    check("t3_drained", 16'(level), 16'h0);

    // overflow: samples 9 and 10 are dropped
    ready_out = 1'b0;
    stream(1, 10);
    @(negedge clk);
    check("t4_level", 16'(level), 16'd8);
    check("t4_ovf", 16'(ovf_flag), 16'h1);
    ready_out = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t4_order", data_out, 16'(i));
      @(negedge clk);
    end
    check("t4_drained", 16'(valid_out), 16'h0);
    pulse_clr();
    check("t4_ovf_clr", 16'(ovf_flag), 16'h0);

    // full FIFO with simultaneous push and pop every cycle
    ready_out = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (k == 10) ready_out = 1'b1;
      valid_in = 1'b1;
      data_in  = 33'(k) << 15;
      if (k >= 10) begin
        check("t5_level", 16'(level), 16'd8);
        check("t5_order", data_out, 16'(k - 9));
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    for (int k = 21; k <= 29; k++) begin
      check("t5_drain", data_out, 16'(k));
      @(negedge clk);
    end
    check("t5_empty", 16'(level), 16'h0);
    check("t5_ovf", 16'(ovf_flag), 16'h0);

    // asynchronous reset mid-stream
    ready_out = 1'b0;
    stream(1, 5);
    @(negedge clk);
    check("t6_level", 16'(level), 16'd5);
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 16'(valid_out), 16'h0);
    check("t6_async_level", 16'(level), 16'h0);
    check("t6_async_data", data_out, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    ready_out = 1'b1;
    send1(33'(3) << 15);
    check("t6_early", 16'(valid_out), 16'h0);
    @(negedge clk);
    check("t6_valid", 16'(valid_out), 16'h1);
    check("t6_data", data_out, 16'd3);
    @(negedge clk);
    check("t6_empty", 16'(level), 16'h0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
